// File: rtl/mips5_proc.sv
// Five-stage pipelined MIPS-subset core (IF/ID/EX/MEM/WB) with Harvard memory ports.
// Hazards are handled by EX forwarding, load-use stalls, EX branch flush and ID jump flush.
module mips5_proc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mrd_i,
    output logic [31:0] mwd_i,
    output logic [31:0] mra_i,
    output logic [31:0] mwa_i,
    output logic        mwr_i,
    input  logic [31:0] mrd_d,
    output logic [31:0] mwd_d,
    output logic [31:0] mra_d,
    output logic [31:0] mwa_d,
    output logic        mwr_d
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dst;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [31:0] val;
        logic [4:0]  dst;
    } memwb_t;

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [31:0] rf_q [32];

    opcode_e     id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [31:0] id_imm, id_rs_val, id_rt_val, id_jtarget;
    logic [4:0]  id_dst;
    ctrl_t       id_ctrl;
    logic        id_jump;
    logic        load_use;
    logic        wb_we;

    logic [31:0] ex_a, ex_b, ex_opb, ex_res, br_target;
    logic        br_taken;

    assign id_op      = opcode_e'(ifid_q.instr[31:26]);
    assign id_rs      = ifid_q.instr[25:21];
    assign id_rt      = ifid_q.instr[20:16];
    assign id_rd      = ifid_q.instr[15:11];
    assign id_funct   = ifid_q.instr[5:0];
    assign id_imm     = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    assign id_jtarget = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
    assign wb_we      = memwb_q.reg_write && (memwb_q.dst != 5'd0);

    // Decode: unsupported encodings leave every control bit clear and behave as NOP.
    always_comb begin
        id_ctrl = '0;
        id_jump = 1'b0;
        id_dst  = id_rt;
        case (id_op)
            OP_RTYPE: begin
                id_dst = id_rd;
                case (id_funct)
                    6'h20: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
                    6'h22: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SUB; end
                    6'h24: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
                    6'h25: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
                    6'h2A: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                id_ctrl.mem_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = ALU_SUB;
            end
            OP_J: id_jump = 1'b1;
            default: ;
        endcase
    end

    // Register read with write-through from WB so a same-cycle write is visible.
    always_comb begin
        id_rs_val = rf_q[id_rs];
        if (id_rs == 5'd0) begin
            id_rs_val = '0;
        end else if (wb_we && memwb_q.dst == id_rs) begin
            id_rs_val = memwb_q.val;
        end
        id_rt_val = rf_q[id_rt];
        if (id_rt == 5'd0) begin
            id_rt_val = '0;
        end else if (wb_we && memwb_q.dst == id_rt) begin
            id_rt_val = memwb_q.val;
        end
    end

    assign load_use = idex_q.ctrl.mem_read && ((idex_q.rt == id_rs) || (idex_q.rt == id_rt));

    always_comb begin
        ex_a = idex_q.rs_val;
        if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs) begin
            ex_a = exmem_q.alu;
        end else if (wb_we && memwb_q.dst == idex_q.rs) begin
            ex_a = memwb_q.val;
        end
        ex_b = idex_q.rt_val;
        if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt) begin
            ex_b = exmem_q.alu;
        end else if (wb_we && memwb_q.dst == idex_q.rt) begin
            ex_b = memwb_q.val;
        end
        ex_opb = idex_q.ctrl.alu_src ? idex_q.imm : ex_b;
        case (idex_q.ctrl.alu_op)
            ALU_SUB: ex_res = ex_a - ex_opb;
            ALU_AND: ex_res = ex_a & ex_opb;
            ALU_OR:  ex_res = ex_a | ex_opb;
            ALU_SLT: ex_res = {31'd0, $signed(ex_a) < $signed(ex_opb)};
            default: ex_res = ex_a + ex_opb;
        endcase
        br_taken  = idex_q.ctrl.branch && (ex_a == ex_b);
        br_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
    end

    // Front-end steering: taken branch beats load-use stall, which beats jump.
    always_comb begin
        pc_d          = pc_q + 32'd4;
        ifid_d.instr  = mrd_i;
        ifid_d.pc4    = pc_q + 32'd4;
        idex_d.ctrl   = id_ctrl;
        idex_d.rs_val = id_rs_val;
        idex_d.rt_val = id_rt_val;
        idex_d.imm    = id_imm;
        idex_d.pc4    = ifid_q.pc4;
        idex_d.rs     = id_rs;
        idex_d.rt     = id_rt;
        idex_d.dst    = id_dst;
        if (br_taken) begin
            pc_d   = br_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (load_use) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end else if (id_jump) begin
            pc_d   = id_jtarget;
            ifid_d = '0;
        end
    end

    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
        exmem_d.alu        = ex_res;
        exmem_d.st         = ex_b;
        exmem_d.dst        = idex_q.dst;

        memwb_d            = '0;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.val        = exmem_q.mem_to_reg ? mrd_d : exmem_q.alu;
        memwb_d.dst        = exmem_q.dst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            if (wb_we) begin
                rf_q[memwb_q.dst] <= memwb_q.val;
            end
        end
    end

    assign mra_i = pc_q;
    assign mwd_i = '0;
    assign mwa_i = '0;
    assign mwr_i = 1'b0;
    assign mra_d = exmem_q.alu;
    assign mwa_d = exmem_q.alu;
    assign mwd_d = exmem_q.st;
    assign mwr_d = exmem_q.mem_write;

endmodule

// File: tb/tb_mips5_proc.sv
// Bench for mips5_proc: directed and random programs checked against an
// instruction-level reference interpreter with a per-instruction cycle cost model.
module tb_mips5_proc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mrd_i, mwd_i, mra_i, mwa_i;
    logic        mwr_i;
    logic [31:0] mrd_d, mwd_d, mra_d, mwa_d;
    logic        mwr_d;

    logic [31:0] imem    [256];
    logic [31:0] dmem    [256];
    logic [31:0] mdl_mem [256];
    logic [31:0] prog    [$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          mdl_cycles;
    int          checks   = 0;
    int          failures = 0;

    logic [5:0] fns     [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] bad_ops [4] = '{6'h3F, 6'h0D, 6'h01, 6'h2F};

    always #5 clk = ~clk;

    assign mrd_i = imem[mra_i[9:2]];
    assign mrd_d = dmem[mra_d[9:2]];

    mips5_proc dut (
        .clk   (clk),
        .rst   (rst),
        .mrd_i (mrd_i),
        .mwd_i (mwd_i),
        .mra_i (mra_i),
        .mwa_i (mwa_i),
        .mwr_i (mwr_i),
        .mrd_d (mrd_d),
        .mwd_d (mwd_d),
        .mra_d (mra_d),
        .mwa_d (mwa_d),
        .mwr_d (mwr_d)
    );

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural interpreter: executes until the halt address and prices each
    // instruction at one cycle, plus one per load-use pair, two per taken beq, one per j.
    task automatic run_model(input logic [31:0] halt_addr);
        logic [31:0] r [32];
        logic [31:0] pc, ins, a, b, imm, nxt, ea;
        int          lw_dst;
        for (int i = 0; i < 32; i++) r[i] = '0;
        exp_addr.delete();
        exp_data.delete();
        mdl_cycles = 0;
        pc         = '0;
        lw_dst     = -1;
        for (int steps = 0; steps < 5000 && pc != halt_addr; steps++) begin
            ins = imem[pc[9:2]];
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            if (lw_dst > 0 && (int'(ins[25:21]) == lw_dst || int'(ins[20:16]) == lw_dst))
                mdl_cycles++;
            lw_dst = -1;
            mdl_cycles++;
            nxt = pc + 32'd4;
            case (ins[31:26])
                6'h00: case (ins[5:0])
                    6'h20: r[ins[15:11]] = a + b;
                    6'h22: r[ins[15:11]] = a - b;
                    6'h24: r[ins[15:11]] = a & b;
                    6'h25: r[ins[15:11]] = a | b;
                    6'h2A: r[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ;
                endcase
                6'h08: r[ins[20:16]] = a + imm;
                6'h23: begin
                    ea             = a + imm;
                    r[ins[20:16]]  = mdl_mem[ea[9:2]];
                    lw_dst         = int'(ins[20:16]);
                end
                6'h2B: begin
                    ea = a + imm;
                    exp_addr.push_back(ea);
                    exp_data.push_back(b);
                    mdl_mem[ea[9:2]] = b;
                end
                6'h04: if (a == b) begin
                    nxt        = pc + 32'd4 + (imm << 2);
                    mdl_cycles = mdl_cycles + 2;
                end
                6'h02: begin
                    nxt = pc + 32'd4;
                    nxt = {nxt[31:28], ins[25:0], 2'b00};
                    mdl_cycles++;
                end
                default: ;
            endcase
            r[0] = '0;
            pc   = nxt;
        end
    endtask

    // Appends a dump of every register to address 4*r, then a jump-to-self halt.
    task automatic run_prog(input string tag, input int exp_halt, input int stop_at);
        int          c, n_obs, halt_cycle, bound, mism;
        bit          halted;
        logic [31:0] halt_addr;
        for (int r = 0; r < 32; r++) prog.push_back(i_ins(6'h2B, 5'd0, 5'(r), 16'(4 * r)));
        halt_addr = 32'(prog.size() * 4);
        prog.push_back(j_ins(26'(prog.size())));

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, ":rst_mra_i"}, mra_i, '0);
        check({tag, ":rst_mwr_d"}, 32'(mwr_d), '0);
        check({tag, ":rst_mra_d"}, mra_d, '0);
        check({tag, ":rst_mwa_d"}, mwa_d, '0);
        check({tag, ":rst_mwd_d"}, mwd_d, '0);
        check({tag, ":rst_imem_wr"}, {mwd_i[30:0] | mwa_i[30:0], mwr_i}, '0);
        for (int i = 0; i < 256; i++) begin
            imem[i]    = (i < prog.size()) ? prog[i] : '0;
            dmem[i]    = $urandom;
            mdl_mem[i] = dmem[i];
        end
        run_model(halt_addr);
        rst        = 1'b0;
        c          = 0;
        n_obs      = 0;
        halted     = 1'b0;
        halt_cycle = -1;
        bound      = mdl_cycles + 100;
        while (1) begin
            if (!halted && mra_i == halt_addr) begin
                halted     = 1'b1;
                halt_cycle = c;
            end
            if (mwr_d) begin
                checks++;
                assert (n_obs < exp_addr.size()) else begin
                    failures++;
                    $error("FAIL %s:extra_store observed=%0d stores expected=%0d", tag, n_obs + 1, exp_addr.size());
                end
                if (n_obs < exp_addr.size()) begin
                    check($sformatf("%s:st%0d_addr", tag, n_obs), mwa_d, exp_addr[n_obs]);
                    check($sformatf("%s:st%0d_data", tag, n_obs), mwd_d, exp_data[n_obs]);
                end
                dmem[mwa_d[9:2]] = mwd_d;
                n_obs++;
            end
            if (stop_at > 0 && c >= stop_at) break;
            if ((halted && c >= halt_cycle + 8) || c >= bound) break;
            @(negedge clk);
            c++;
        end
        if (stop_at == 0) begin
            check({tag, ":halted"}, 32'(halted), 32'd1);
            check({tag, ":halt_cycle"}, 32'(halt_cycle), 32'(exp_halt >= 0 ? exp_halt : mdl_cycles));
            check({tag, ":store_count"}, 32'(n_obs), 32'(exp_addr.size()));
            mism = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== mdl_mem[i]) mism++;
            check({tag, ":dmem_words_differing"}, 32'(mism), '0);
        end
    endtask

    task automatic gen_random(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            int          sel = $urandom_range(0, 99);
            int          k   = $urandom_range(0, 3);
            logic [4:0]  rs  = 5'($urandom_range(0, 7));
            logic [4:0]  rt  = 5'($urandom_range(0, 7));
            logic [4:0]  rd  = 5'($urandom_range(0, 7));
            logic [15:0] imm = 16'($urandom);
            if (i + 1 + k > n) k = n - i - 1;
            if (sel < 40)      prog.push_back(r_ins(rs, rt, rd, fns[$urandom_range(0, 4)]));
            else if (sel < 55) prog.push_back(i_ins(6'h08, rs, rt, imm));
            else if (sel < 65) prog.push_back(i_ins(6'h23, rs, 5'($urandom_range(1, 7)), imm));
            else if (sel < 75) prog.push_back(i_ins(6'h2B, rs, rt, imm));
            else if (sel < 83) prog.push_back(i_ins(6'h04, rs, rt, 16'(k)));
            else if (sel < 88) prog.push_back(j_ins(26'(i + 1 + k)));
            else if (sel < 94) prog.push_back({bad_ops[$urandom_range(0, 3)], 26'($urandom)});
            else               prog.push_back(r_ins(rs, rt, rd, 6'h21));
        end
    endtask

    initial begin
        // ALU chain, all dependencies satisfied by forwarding
        prog.delete();
        prog.push_back(i_ins(6'h08, 5'd0, 5'd1, 16'd5));
        prog.push_back(i_ins(6'h08, 5'd0, 5'd2, 16'd7));
        prog.push_back(r_ins(5'd1, 5'd2, 5'd3, 6'h20));
        prog.push_back(r_ins(5'd3, 5'd1, 5'd4, 6'h22));
        prog.push_back(r_ins(5'd1, 5'd2, 5'd5, 6'h2A));
        prog.push_back(r_ins(5'd3, 5'd2, 5'd6, 6'h24));
        prog.push_back(r_ins(5'd1, 5'd2, 5'd7, 6'h25));
        run_prog("alu", 39, 0);
        check("alu:r3", dmem[3], 32'd12);
        check("alu:r4", dmem[4], 32'd7);
        check("alu:r5", dmem[5], 32'd1);
        check("alu:r6", dmem[6], 32'd4);
        check("alu:r7", dmem[7], 32'd7);

        // store, load, dependent add: one bubble
        prog.delete();
        prog.push_back(i_ins(6'h08, 5'd0, 5'd1, 16'h002A));
        prog.push_back(i_ins(6'h2B, 5'd0, 5'd1, 16'd8));
        prog.push_back(i_ins(6'h23, 5'd0, 5'd2, 16'd8));
        prog.push_back(r_ins(5'd2, 5'd2, 5'd3, 6'h20));
        run_prog("ldst", 37, 0);
        check("ldst:r2", dmem[2], 32'h2A);
        check("ldst:r3", dmem[3], 32'h54);

        // taken beq skips two, then a not-taken beq falls through
        prog.delete();
        prog.push_back(i_ins(6'h08, 5'd0, 5'd1, 16'd3));
        prog.push_back(i_ins(6'h04, 5'd1, 5'd1, 16'd2));
        prog.push_back(i_ins(6'h08, 5'd0, 5'd2, 16'd1));
        prog.push_back(i_ins(6'h08, 5'd0, 5'd2, 16'd2));
        prog.push_back(i_ins(6'h08, 5'd0, 5'd4, 16'd9));
        prog.push_back(i_ins(6'h04, 5'd0, 5'd1, 16'd5));
        run_prog("beq", 38, 0);
        check("beq:r1", dmem[1], 32'd3);
        check("beq:r2", dmem[2], 32'd0);
        check("beq:r4", dmem[4], 32'd9);

        // jump over one instruction and two NOPs
        prog.delete();
        prog.push_back(j_ins(26'd4));
        prog.push_back(i_ins(6'h08, 5'd0, 5'd2, 16'd5));
        prog.push_back(32'h0);
        prog.push_back(32'h0);
        prog.push_back(i_ins(6'h08, 5'd0, 5'd3, 16'd6));
        run_prog("jmp", 35, 0);
        check("jmp:r2", dmem[2], 32'd0);
        check("jmp:r3", dmem[3], 32'd6);

        // random programs, one interrupted by reset mid-flight
        gen_random(40);
        run_prog("rnd_cut", -1, 23);
        for (int t = 0; t < 6; t++) begin
            gen_random(40);
            run_prog($sformatf("rnd%0d", t), -1, 0);
        end

        // write to $0 and unknown opcode after registers were dirtied above
        prog.delete();
        prog.push_back(i_ins(6'h08, 5'd0, 5'd0, 16'd5));
        prog.push_back({6'h3F, 26'($urandom)});
        run_prog("zero", 34, 0);
        check("zero:r0", dmem[0], 32'd0);
        check("zero:r1", dmem[1], 32'd0);
        check("zero:r31", dmem[31], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
